// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
// Optional feature macro: DIVIDER_REMAINDER_EN (see divider.sv).
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_t;

    function automatic int div_iters(input int width, input int frac);
        return width + frac;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration.
// Shift in the next numerator bit, try to subtract, restore on borrow.
module div_step #(
    parameter int C_WIDTH = 32
) (
    input  logic [C_WIDTH-1:0] rem,
    input  logic               num_bit,
    input  logic [C_WIDTH-1:0] divisor,
    output logic [C_WIDTH-1:0] rem_next,
    output logic               q_bit
);

    logic [C_WIDTH:0]   shifted;
    logic [C_WIDTH+1:0] diff;

    // trial subtraction; the top bit of diff is the borrow
    always_comb begin
        shifted  = {rem, num_bit};
        diff     = {1'b0, shifted} - {2'b00, divisor};
        q_bit    = ~diff[C_WIDTH+1];
        rem_next = q_bit ? C_WIDTH'(diff) : C_WIDTH'(shifted);
    end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, unsigned or two's-complement, fixed-point.
// Macro DIVIDER_REMAINDER_EN: drive r with the sign-corrected remainder.
module divider
    import div_pkg::*;
#(
    parameter int C_WIDTH     = 32,
    parameter int FIXED_POINT = 0
) (
    input  logic               ctl_clk,
    input  logic               reset,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    input  logic               signed_cal,
    input  logic               trigger,
    output logic               ready,
    output logic               done,
    output logic [C_WIDTH-1:0] y,
    output logic [C_WIDTH-1:0] r,
    output logic               div_by_zero
);

    localparam int N     = div_iters(C_WIDTH, FIXED_POINT);
    localparam int CNT_W = $clog2(N + 1);

    div_state_t state, state_next;

    logic               load;
    logic               step;
    logic               finish;
    logic               b_zero;
    logic [N-1:0]       num;
    logic [N-1:0]       quo;
    logic [C_WIDTH-1:0] rem;
    logic [C_WIDTH-1:0] rem_next;
    logic [C_WIDTH-1:0] divisor;
    logic [C_WIDTH-1:0] a_mag;
    logic [C_WIDTH-1:0] b_mag;
    logic [C_WIDTH-1:0] q_low;
    logic [CNT_W-1:0]   cnt;
    logic               q_bit;
    logic               sgn;
    logic               neg_q;
    logic               neg_r;
    logic               dbz;

    function automatic logic [C_WIDTH-1:0] mag(
        input logic [C_WIDTH-1:0] v,
        input logic               s
    );
        return (s && v[C_WIDTH-1]) ? -v : v;
    endfunction

    assign b_zero = (b == '0);
    assign a_mag  = mag(a, signed_cal);
    assign b_mag  = mag(b, signed_cal);
    assign q_low  = quo[C_WIDTH-1:0];

    div_step #(
        .C_WIDTH(C_WIDTH)
    ) u_step (
        .rem     (rem),
        .num_bit (num[N-1]),
        .divisor (divisor),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    // state register
    always_ff @(posedge ctl_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next state and control strobes
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (trigger) begin
                    load       = 1'b1;
                    state_next = b_zero ? FIX : CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == '0) state_next = FIX;
            end
            FIX: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // operand capture and iteration datapath
    always_ff @(posedge ctl_clk or posedge reset) begin
        if (reset) begin
            num     <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dbz     <= 1'b0;
        end else if (load) begin
            num     <= N'(a_mag) << FIXED_POINT;
            quo     <= '0;
            rem     <= b_zero ? a : '0;
            divisor <= b_mag;
            cnt     <= CNT_W'(N - 1);
            sgn     <= signed_cal;
            neg_q   <= signed_cal & (a[C_WIDTH-1] ^ b[C_WIDTH-1]);
            neg_r   <= signed_cal & a[C_WIDTH-1];
            dbz     <= b_zero;
        end else if (step) begin
            num <= num << 1;
            quo <= {quo[N-2:0], q_bit};
            rem <= rem_next;
            cnt <= cnt - 1'b1;
        end
    end

    // quotient, divide-by-zero flag and done pulse
    always_ff @(posedge ctl_clk or posedge reset) begin
        if (reset) begin
            y           <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                div_by_zero <= dbz;
                if (dbz)
                    y <= sgn ? {neg_r, {(C_WIDTH-1){~neg_r}}} : '1;
                else
                    y <= neg_q ? -q_low : q_low;
            end
        end
    end

`ifdef DIVIDER_REMAINDER_EN
    // remainder follows the sign of the dividend; raw a on divide by zero
    always_ff @(posedge ctl_clk or posedge reset) begin
        if (reset)       r <= '0;
        else if (finish) r <= (neg_r && !dbz) ? -rem : rem;
    end
`else
    assign r = '0;
`endif

endmodule

// File: tb/tb_divider.sv
// Randomized self-checking bench for divider (8-bit, FIXED_POINT 0 and 4).
// Expected r depends on DIVIDER_REMAINDER_EN.
module tb_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a   = '0;
    logic [7:0] b   = '0;
    logic       sc  = 1'b0;
    logic       t0  = 1'b0;
    logic       t4  = 1'b0;

    logic       rdy0, dn0, z0;
    logic [7:0] y0, r0;
    logic       rdy4, dn4, z4;
    logic [7:0] y4, r4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divider #(.C_WIDTH(8), .FIXED_POINT(0)) u0 (
        .ctl_clk(clk), .reset(rst), .a(a), .b(b), .signed_cal(sc),
        .trigger(t0), .ready(rdy0), .done(dn0), .y(y0), .r(r0),
        .div_by_zero(z0)
    );

    divider #(.C_WIDTH(8), .FIXED_POINT(4)) u4 (
        .ctl_clk(clk), .reset(rst), .a(a), .b(b), .signed_cal(sc),
        .trigger(t4), .ready(rdy4), .done(dn4), .y(y4), .r(r4),
        .div_by_zero(z4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // reference: plain integer division on magnitudes
    task automatic model(input logic [7:0] av, input logic [7:0] bv,
                         input logic sg, input int fp,
                         output logic [7:0] ey, output logic [7:0] er,
                         output logic ez);
        longint na, nb, q, rm;
        if (bv == 8'h00) begin
            ez = 1'b1;
            er = av;
            if (!sg)        ey = 8'hFF;
            else if (av[7]) ey = 8'h80;
            else            ey = 8'h7F;
        end else begin
            ez = 1'b0;
            na = sg ? longint'($signed(av)) : longint'(av);
            nb = sg ? longint'($signed(bv)) : longint'(bv);
            q  = ((na < 0 ? -na : na) << fp) / (nb < 0 ? -nb : nb);
            rm = ((na < 0 ? -na : na) << fp) % (nb < 0 ? -nb : nb);
            if (sg && ((na < 0) != (nb < 0))) q = -q;
            if (sg && na < 0) rm = -rm;
            ey = q[7:0];
            er = rm[7:0];
        end
`ifndef DIVIDER_REMAINDER_EN
        er = 8'h00;
`endif
    endtask

    function automatic logic dn_of(input bit fp4);
        return fp4 ? dn4 : dn0;
    endfunction

    function automatic logic rdy_of(input bit fp4);
        return fp4 ? rdy4 : rdy0;
    endfunction

    task automatic accept(input bit fp4, input logic [7:0] av,
                          input logic [7:0] bv, input logic sg);
        @(negedge clk);
        a  = av;
        b  = bv;
        sc = sg;
        if (fp4) t4 = 1'b1;
        else     t0 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // called #1 after the accepting edge
    task automatic collect(input bit fp4, input logic [7:0] av,
                           input logic [7:0] bv, input logic sg);
        logic [7:0] ey, er;
        logic       ez;
        int         n;
        int         lat;
        n = 0;
        model(av, bv, sg, fp4 ? 4 : 0, ey, er, ez);
        lat = (bv == 8'h00) ? 1 : (fp4 ? 13 : 9);
        chk("busy", 32'(rdy_of(fp4)), 0);
        while (!dn_of(fp4) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, lat);
        chk("y", fp4 ? y4 : y0, ey);
        chk("r", fp4 ? r4 : r0, er);
        chk("dbz", 32'(fp4 ? z4 : z0), 32'(ez));
        chk("ready_at_done", 32'(rdy_of(fp4)), 1);
    endtask

    task automatic op(input bit fp4, input logic [7:0] av,
                      input logic [7:0] bv, input logic sg);
        accept(fp4, av, bv, sg);
        t0 = 1'b0;
        t4 = 1'b0;
        a  = 8'($urandom);
        b  = 8'($urandom);
        sc = 1'($urandom);
        collect(fp4, av, bv, sg);
        @(posedge clk);
        #1;
        chk("pulse", 32'(dn_of(fp4)), 0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        int         nd;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_y", y0, 0);
        chk("rst_r", r0, 0);
        chk("rst_done", 32'(dn0), 0);
        chk("rst_ready", 32'(rdy0), 1);
        chk("rst_dbz", 32'(z0), 0);
        chk("rst_ready4", 32'(rdy4), 1);

        op(0, 8'h75, 8'h13, 1'b0);
        op(0, 8'h05, 8'hFD, 1'b1);
        op(0, 8'hF9, 8'h02, 1'b1);
        op(0, 8'h75, 8'h00, 1'b0);
        op(0, 8'hF9, 8'h00, 1'b1);
        op(0, 8'h80, 8'hFF, 1'b1);
        op(0, 8'hFF, 8'h01, 1'b0);
        op(4, 8'h30, 8'h20, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            op(0, ra, rb, 1'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            op(1, ra, rb, 1'($urandom));
        end

        // a trigger pulse in mid-calculation must not start another divide
        accept(0, 8'h75, 8'h13, 1'b0);
        t0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        t0 = 1'b1;
        @(posedge clk);
        #1;
        t0 = 1'b0;
        nd = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (dn0) begin
                nd++;
                chk("busy_trig_y", y0, 8'h06);
            end
        end
        chk("one_done", nd, 1);

        // back-to-back: trigger held through the done cycle
        accept(0, 8'hC8, 8'h07, 1'b0);
        a  = 8'h9C;
        b  = 8'hF6;
        sc = 1'b1;
        collect(0, 8'hC8, 8'h07, 1'b0);
        @(posedge clk);
        #1;
        t0 = 1'b0;
        collect(0, 8'h9C, 8'hF6, 1'b1);

        // leave nonzero results behind, then abort mid-calculation
        op(0, 8'hF9, 8'h00, 1'b1);
        accept(0, 8'h75, 8'h13, 1'b0);
        t0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_y", y0, 0);
        chk("abort_r", r0, 0);
        chk("abort_done", 32'(dn0), 0);
        chk("abort_ready", 32'(rdy0), 1);
        chk("abort_dbz", 32'(z0), 0);
        @(negedge clk);
        rst = 1'b0;
        op(0, 8'h64, 8'h09, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider.md
# divider

Sequential radix-2 restoring divider computing y = a / b (and remainder r) on C_WIDTH-bit operands, unsigned or two's-complement, with optional fixed-point scaling. It is the inverse-operation companion to `multiplier` in the synthesizer arithmetic library. It uses the same trigger/ready/done handshake so control FSMs can drive either unit interchangeably.

## Interface
- C_WIDTH, 32, operand and result width in bits.
- FIXED_POINT, 0, number of fractional bits. Dividend is scaled by 2^FIXED_POINT before division.
- ctl_clk  input  1  sole clock, rising-edge.
- reset  input  1  asynchronous, active-high. One clock; reset is asynchronous and active-high.
- a  input  C_WIDTH  dividend, sampled on the accepting edge only.
- b  input  C_WIDTH  divisor, sampled on the accepting edge only.
- signed_cal  input  1  1 = two's-complement; sampled with operands.
- trigger  input  1  start request; level-sampled on rising edge.
- ready  output  1  unit idle, accepts trigger.
- done  output  1  one-cycle pulse when y/r are valid.
- y  output  C_WIDTH  quotient, held until next completion.
- r  output  C_WIDTH  remainder, held until next completion.
- div_by_zero  output  1  last result came from b == 0; held with y.

## Operation
- N = C_WIDTH + FIXED_POINT iterations. Internal numerator is |a| << FIXED_POINT, N bits wide.
- FSM states:
  - IDLE: ready=1. trigger=1 latches a, b, signed_cal and goes to CALC, or to FIX if b == 0.
  - CALC: one quotient bit per cycle, MSB first. Shift remainder left, subtract |b|, restore if negative. Runs N cycles, then goes to FIX.
  - FIX: apply sign correction, register y/r/div_by_zero, pulse done. Returns to IDLE.
- Signed mode:
  - Operate on magnitudes.
  - Negate the quotient if sign(a) != sign(b).
  - Remainder takes the sign of a (truncation toward zero).
- Quotient is the low C_WIDTH bits of the N-bit result; overflow wraps, no saturation. Signed 0x80 / 0xFF (C_WIDTH=8) gives y=0x80.
- Divide by zero: no iterations. div_by_zero=1 and r=a.
  - Unsigned: y=all ones.
  - Signed: y=max positive if a >= 0, min negative if a < 0.
- trigger while ready=0 is ignored, not queued. Operand changes after acceptance are ignored.

## Timing
- Reset values:
  - y, r: 0.
  - done, div_by_zero: 0.
  - ready: 1.
  - State: IDLE.
- Latency, with trigger accepted at edge k:
  - ready=0 from edge k.
  - Normal divide: done=1 after edge k+N+1, for exactly one cycle.
  - Divide by zero: done=1 after edge k+1.
- ready returns to 1 in the same cycle done is high. trigger during that cycle is accepted, giving back-to-back operations with no bubble.
- Reset mid-operation aborts immediately. Outputs return to reset values asynchronously; the partial result is discarded.
- y/r/div_by_zero change only on the done edge.

## Configuration
- DIVIDER_REMAINDER_EN defined: r is driven with the sign-corrected remainder as specified.
- DIVIDER_REMAINDER_EN undefined:
  - r is tied to 0.
  - The output remainder register and remainder sign-fix logic are removed.
  - The internal working remainder is retained for the algorithm.
  - Quotient behaviour and timing are unchanged.

## Structure
- Shared package `div_pkg`:
  - FSM state typedef (IDLE, CALC, FIX).
  - Function computing N from C_WIDTH and FIXED_POINT.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: partial remainder, next numerator bit, |b|.
  - Outputs: new remainder, quotient bit.
  - Instantiated once; the top-level FSM, counter and sign logic surround it.

## Test plan
All scenarios use C_WIDTH=8, FIXED_POINT=0 and DIVIDER_REMAINDER_EN defined unless stated.
- Unsigned 0x75 / 0x13 -> y=0x06, r=0x03, div_by_zero=0. done exactly 9 edges after the accepting edge; ready low during CALC.
- Signed 0x05 / 0xFD (5 / -3) -> y=0xFF, r=0x02. Signed 0xF9 / 0x02 (-7 / 2) -> y=0xFD, r=0xFF.
- Divide by zero:
  - Unsigned 0x75 / 0x00 -> y=0xFF, r=0x75, div_by_zero=1, done 1 edge after trigger.
  - Signed 0xF9 / 0x00 -> y=0x80.
- Reset and busy handling:
  - reset asserted during CALC cycle 4 -> y=0, r=0, done=0, ready=1 without a clock edge.
  - A trigger pulse during CALC is ignored: exactly one done per accepted trigger.
- Back-to-back: trigger held high across the done cycle starts a second divide with new operands; its result arrives N+1 edges later.
- FIXED_POINT=4: 0x30 / 0x20 (3.0 / 2.0) -> y=0x18 (1.5), r=0x00, done after 13 edges. Repeat without DIVIDER_REMAINDER_EN -> r stays 0.
